gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl_if.sv | 29 ++
 rtl/gate_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// gate_sweep_ctrl_if : handshake/status bundle between sweep controller and host
// Revision: 1.0
// ============================================================================
interface gate_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [7:0]  g_out;
  logic        in1;
  logic        in2;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  err_count;
  logic [3:0]  fail_mask;
  logic [31:0] result;

  modport master (
    output start, abort, g_out,
    input  in1, in2, busy, done, pass, err_count, fail_mask, result
  );

  modport slave (
    input  start, abort, g_out,
    output in1, in2, busy, done, pass, err_count, fail_mask, result
  );
endinterface
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// gate_sweep_ctrl : sweeps {in1,in2} over 00..11 and checks an 8-gate unit
// Revision: 1.0
// ============================================================================
module gate_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  gate_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in1_q, in1_d;
  logic        in2_q, in2_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [2:0]  err_q, err_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] result_q, result_d;

  logic [7:0]  w_exp;
  logic [1:0]  w_vec_nxt;

  // Bit order matches g_out: buffer,xnor,xor,nor,nand,not,or,and (MSB..LSB)
  assign w_exp = {in1_q, ~(in1_q ^ in2_q), in1_q ^ in2_q, ~(in1_q | in2_q),
                  ~(in1_q & in2_q), ~in1_q, in1_q | in2_q, in1_q & in2_q};
  assign w_vec_nxt = vec_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          result_d = '0;
          err_d    = '0;
          mask_d   = '0;
          pass_d   = 1'b0;
          vec_d    = 2'd0;
          cnt_d    = '0;
          in1_d    = 1'b0;
          in2_d    = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          in1_d   = 1'b0;
          in2_d   = 1'b0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          state_d = S_IDLE;
        end else if (cnt_q == c_SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          in1_d   = 1'b0;
          in2_d   = 1'b0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          result_d[{vec_q, 3'b000} +: 8] = bus.g_out;
          // A vector counts once no matter how many gate bits disagree
          if (bus.g_out != w_exp) begin
            mask_d[vec_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            vec_d          = w_vec_nxt;
            {in1_d, in2_d} = w_vec_nxt;
            cnt_d          = '0;
            state_d        = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        in1_d   = 1'b0;
        in2_d   = 1'b0;
        vec_d   = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      result_q <= result_d;
    end
  end

  assign bus.in1       = in1_q;
  assign bus.in2       = in2_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gate_sweep_ctrl : directed bench for gate_sweep_ctrl, SETTLE=2 and SETTLE=1
// Revision: 1.0
// ============================================================================
module tb_gate_sweep_ctrl;

  logic clk;
  logic rst_n;
  logic st [2];
  logic ab [2];
  logic [7:0] stuck [2];

  int checks;
  int failures;

  logic [1:0] io_log   [0:31];
  logic       busy_log [0:31];

  gate_sweep_ctrl_if bus0 ();
  gate_sweep_ctrl_if bus1 ();

  function automatic logic [7:0] gate_model(input logic a, input logic b);
    return {a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  assign bus0.start = st[0];
  assign bus0.abort = ab[0];
  assign bus0.g_out = gate_model(bus0.in1, bus0.in2) | stuck[0];
  assign bus1.start = st[1];
  assign bus1.abort = ab[1];
  assign bus1.g_out = gate_model(bus1.in1, bus1.in2) | stuck[1];

  gate_sweep_ctrl #(.SETTLE(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate_sweep_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic        in1_w  [2];
  logic        in2_w  [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [2:0]  err_w  [2];
  logic [3:0]  mask_w [2];
  logic [31:0] res_w  [2];

  assign in1_w[0] = bus0.in1;        assign in1_w[1] = bus1.in1;
  assign in2_w[0] = bus0.in2;        assign in2_w[1] = bus1.in2;
  assign busy_w[0] = bus0.busy;      assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus0.done;      assign done_w[1] = bus1.done;
  assign pass_w[0] = bus0.pass;      assign pass_w[1] = bus1.pass;
  assign err_w[0] = bus0.err_count;  assign err_w[1] = bus1.err_count;
  assign mask_w[0] = bus0.fail_mask; assign mask_w[1] = bus1.fail_mask;
  assign res_w[0] = bus0.result;     assign res_w[1] = bus1.result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input int k, input string tag);
    check({tag, " in"},     {30'd0, in1_w[k], in2_w[k]}, 32'd0);
    check({tag, " busy"},   {31'd0, busy_w[k]}, 32'd0);
    check({tag, " done"},   {31'd0, done_w[k]}, 32'd0);
    check({tag, " pass"},   {31'd0, pass_w[k]}, 32'd0);
    check({tag, " err"},    {29'd0, err_w[k]},  32'd0);
    check({tag, " mask"},   {28'd0, mask_w[k]}, 32'd0);
    check({tag, " result"}, res_w[k], 32'd0);
  endtask

  // Edge 0 is the edge that accepts start; edges are counted from there.
  task automatic sweep(input int k, input int restart_at, input int abort_at,
                       input int max_edges, output int first_done, output int pulses);
    first_done = 0;
    pulses     = 0;
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    for (int i = 1; i <= max_edges; i++) begin
      if (i == restart_at) st[k] = 1'b1;
      if (i == abort_at)   ab[k] = 1'b1;
      tick();
      st[k] = 1'b0;
      ab[k] = 1'b0;
      io_log[i]   = {in1_w[k], in2_w[k]};
      busy_log[i] = busy_w[k];
      if (done_w[k]) begin
        pulses++;
        if (first_done == 0) first_done = i;
      end
    end
  endtask

  int fd, np;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    st[0] = 1'b0; st[1] = 1'b0;
    ab[0] = 1'b0; ab[1] = 1'b0;
    stuck[0] = 8'h00; stuck[1] = 8'h00;

    #3;
    check_all_zero(0, "reset0");
    check_all_zero(1, "reset1");
    #19 rst_n = 1'b1;

    // Clean gate unit
    sweep(0, 0, 0, 20, fd, np);
    check("ok done_edge", fd, 13);
    check("ok pulses", np, 1);
    check("ok in e1", {30'd0, io_log[1]}, 32'd0);
    check("ok in e4", {30'd0, io_log[4]}, 32'd1);
    check("ok in e7", {30'd0, io_log[7]}, 32'd2);
    check("ok in e10", {30'd0, io_log[10]}, 32'd3);
    check("ok busy e12", {31'd0, busy_log[12]}, 32'd1);
    check("ok busy e13", {31'd0, busy_log[13]}, 32'd0);
    check("ok in e13", {30'd0, io_log[13]}, 32'd0);
    check("ok pass", {31'd0, pass_w[0]}, 32'd1);
    check("ok err", {29'd0, err_w[0]}, 32'd0);
    check("ok mask", {28'd0, mask_w[0]}, 32'd0);
    check("ok result", res_w[0], 32'hC3AA2E5C);

    // g_out[0] stuck at 1
    stuck[0] = 8'h01;
    sweep(0, 0, 0, 20, fd, np);
    stuck[0] = 8'h00;
    check("stuck done_edge", fd, 13);
    check("stuck mask", {28'd0, mask_w[0]}, 32'h7);
    check("stuck err", {29'd0, err_w[0]}, 32'd3);
    check("stuck pass", {31'd0, pass_w[0]}, 32'd0);
    check("stuck res0", {24'd0, res_w[0][7:0]}, 32'h5D);
    check("stuck result", res_w[0], 32'hC3AB2F5D);

    // Second start during the sweep is ignored
    sweep(0, 5, 0, 20, fd, np);
    check("restart done_edge", fd, 13);
    check("restart pulses", np, 1);
    check("restart pass", {31'd0, pass_w[0]}, 32'd1);

    // Abort sampled on edge 7 (SETTLE of vector 2)
    sweep(0, 0, 7, 20, fd, np);
    check("abort pulses", np, 0);
    check("abort busy e6", {31'd0, busy_log[6]}, 32'd1);
    check("abort busy e7", {31'd0, busy_log[7]}, 32'd0);
    check("abort in e7", {30'd0, io_log[7]}, 32'd0);
    check("abort pass", {31'd0, pass_w[0]}, 32'd0);
    check("abort result", res_w[0], 32'h00002E5C);
    check("abort mask", {28'd0, mask_w[0]}, 32'd0);

    // Abort while in DONE is ignored
    sweep(0, 0, 13, 20, fd, np);
    check("abort_done edge", fd, 13);
    check("abort_done pass", {31'd0, pass_w[0]}, 32'd1);

    // start and abort together in IDLE
    st[0] = 1'b1; ab[0] = 1'b1; st[1] = 1'b1; ab[1] = 1'b1;
    tick();
    st[0] = 1'b0; ab[0] = 1'b0; st[1] = 1'b0; ab[1] = 1'b0;
    check("both busy0", {31'd0, busy_w[0]}, 32'd0);
    check("both busy1", {31'd0, busy_w[1]}, 32'd0);
    tick();
    check("both busy0 later", {31'd0, busy_w[0]}, 32'd0);

    // Reset mid-SETTLE of vector 2
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (7) tick();
    check("pre_rst busy", {31'd0, busy_w[0]}, 32'd1);
    check("pre_rst in", {30'd0, in1_w[0], in2_w[0]}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero(0, "midrst");
    repeat (2) tick();
    #3 rst_n = 1'b1;
    sweep(0, 0, 0, 20, fd, np);
    check("postrst done_edge", fd, 13);
    check("postrst pulses", np, 1);
    check("postrst result", res_w[0], 32'hC3AA2E5C);

    // SETTLE=1 instance
    sweep(1, 0, 0, 16, fd, np);
    check("s1 done_edge", fd, 9);
    check("s1 pulses", np, 1);
    check("s1 in e1", {30'd0, io_log[1]}, 32'd0);
    check("s1 in e2", {30'd0, io_log[2]}, 32'd1);
    check("s1 in e3", {30'd0, io_log[3]}, 32'd1);
    check("s1 in e4", {30'd0, io_log[4]}, 32'd2);
    check("s1 in e6", {30'd0, io_log[6]}, 32'd3);
    check("s1 result", res_w[1], 32'hC3AA2E5C);
    check("s1 pass", {31'd0, pass_w[1]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
